sap1_datapath: RTL

- Consumer end of the SAP-1 12-bit control word and halt line; the controller drives them, this block obeys them.
- Contains PC, MAR, IR, A accumulator, B register, add/sub ALU, OUT register, 16x8 program RAM and the 8-bit W-bus.
- Returns the IR opcode to the controller; exposes the output value plus a RAM program-load port.

---
 rtl/sap1_pkg.sv | 34 +++
 rtl/sap1_ram16x8.sv | 31 +++
 rtl/sap1_datapath.sv | 118 +++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
`default_nettype none
// ============================================================================
// sap1_pkg : control-word bit map, opcodes and widths shared with the controller
// Revision : 1.0
// ============================================================================
package sap1_pkg;

  localparam int BUS_W  = 8;
  localparam int CTRL_W = 12;

  // Control-word bit indices; bits 2-6, 10 and 11 are active-low.
  localparam int INCR_PC      = 0;
  localparam int PC_EN        = 1;
  localparam int MAR_LOAD     = 2;
  localparam int RAM_EN       = 3;
  localparam int INSTR_LOAD   = 4;
  localparam int INSTR_EN     = 5;
  localparam int A_ACC_LOAD   = 6;
  localparam int A_ACC_EN     = 7;
  localparam int SUB_EN       = 8;
  localparam int ADD_SUB_EN   = 9;
  localparam int B_REG_LOAD   = 10;
  localparam int OUT_REG_LOAD = 11;

  localparam logic [CTRL_W-1:0] IDLE_WORD = 12'hC7C;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage
`default_nettype wire

// File: rtl/sap1_ram16x8.sv
`default_nettype none
// ============================================================================
// sap1_ram16x8 : program RAM, asynchronous read, synchronous program-port write
// Revision : 1.0
// ============================================================================
module sap1_ram16x8
  import sap1_pkg::*;
#(
  parameter int RAM_DEPTH = 16,
  parameter int DATA_W    = BUS_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] r_mem [RAM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule
`default_nettype wire

// File: rtl/sap1_datapath.sv
`default_nettype none
// ============================================================================
// sap1_datapath : SAP-1 registers, add/sub ALU, W-bus mux and program RAM
// Revision : 1.0
// ============================================================================
module sap1_datapath
  import sap1_pkg::*;
#(
  parameter int RAM_DEPTH = 16,
  parameter int DATA_W    = BUS_W
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [11:0]       ctrl_word_i,
  input  logic              hltn_i,
  output logic [3:0]        opcode_o,
  output logic [DATA_W-1:0] out_o,
  output logic              out_valid_o,
  output logic              bus_err_o,
  input  logic              prog_we_i,
  input  logic [3:0]        prog_addr_i,
  input  logic [DATA_W-1:0] prog_data_i
);

  logic [3:0]        r_pc;
  logic [3:0]        r_mar;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_out;
  logic              r_out_valid;
  logic              r_bus_err;

  logic w_incr_pc, w_pc_en, w_mar_load, w_ram_en, w_ir_load, w_ir_en;
  logic w_a_load, w_a_en, w_sub, w_alu_en, w_b_load, w_out_load;
  logic              w_multi_drv;
  logic [DATA_W-1:0] w_ram_rd;
  logic [DATA_W-1:0] w_b_op;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_bus;

  assign w_incr_pc  =  ctrl_word_i[INCR_PC];
  assign w_pc_en    =  ctrl_word_i[PC_EN];
  assign w_mar_load = ~ctrl_word_i[MAR_LOAD];
  assign w_ram_en   = ~ctrl_word_i[RAM_EN];
  assign w_ir_load  = ~ctrl_word_i[INSTR_LOAD];
  assign w_ir_en    = ~ctrl_word_i[INSTR_EN];
  assign w_a_load   = ~ctrl_word_i[A_ACC_LOAD];
  assign w_a_en     =  ctrl_word_i[A_ACC_EN];
  assign w_sub      =  ctrl_word_i[SUB_EN];
  assign w_alu_en   =  ctrl_word_i[ADD_SUB_EN];
  assign w_b_load   = ~ctrl_word_i[B_REG_LOAD];
  assign w_out_load = ~ctrl_word_i[OUT_REG_LOAD];

  sap1_ram16x8 #(
    .RAM_DEPTH (RAM_DEPTH),
    .DATA_W    (DATA_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (prog_we_i),
    .waddr_i (prog_addr_i),
    .wdata_i (prog_data_i),
    .raddr_i (r_mar),
    .rdata_o (w_ram_rd)
  );

  // Two's-complement subtract: A + ~B + 1, carry/borrow dropped by the 8-bit result.
  assign w_b_op = w_sub ? ~r_b : r_b;
  assign w_alu  = r_a + w_b_op + DATA_W'(w_sub);

  assign w_multi_drv = ($countones({w_pc_en, w_ram_en, w_ir_en, w_a_en, w_alu_en}) > 1);

  always_comb begin
    w_bus = '0;
    if (w_pc_en) begin
      w_bus = {{(DATA_W-4){1'b0}}, r_pc};
    end else if (w_ram_en) begin
      w_bus = w_ram_rd;
    end else if (w_ir_en) begin
      w_bus = {{(DATA_W-4){1'b0}}, r_ir[3:0]};
    end else if (w_a_en) begin
      w_bus = r_a;
    end else if (w_alu_en) begin
      w_bus = w_alu;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pc        <= '0;
      r_mar       <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_out_valid <= hltn_i & w_out_load;
      if (hltn_i) begin
        if (w_incr_pc)   r_pc      <= r_pc + 4'd1;
        if (w_mar_load)  r_mar     <= w_bus[3:0];
        if (w_ir_load)   r_ir      <= w_bus;
        if (w_a_load)    r_a       <= w_bus;
        if (w_b_load)    r_b       <= w_bus;
        if (w_out_load)  r_out     <= w_bus;
        if (w_multi_drv) r_bus_err <= 1'b1;
      end
    end
  end

  assign opcode_o    = r_ir[7:4];
  assign out_o       = r_out;
  assign out_valid_o = r_out_valid;
  assign bus_err_o   = r_bus_err;

endmodule
`default_nettype wire
